// File: rtl/bsg_mul_add_pkg.sv
// Shared width helpers for the unsigned multiply-add issue stage.
package bsg_mul_add_pkg;

    function automatic int result_width(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int credit_width(input int els);
        return $clog2(els + 1);
    endfunction

endpackage

// File: rtl/bsg_mul_add_issue_if.sv
// Operand valid/ready channel and result valid/yumi channel of the multiply-add issue stage.
interface bsg_mul_add_issue_if
    import bsg_mul_add_pkg::*;
    #(parameter int width_p = 8) ();

    logic                               v_i;
    logic [width_p-1:0]                 a_i;
    logic [width_p-1:0]                 b_i;
    logic [2*width_p-1:0]               c_i;
    logic                               ready_o;
    logic                               v_o;
    logic [result_width(width_p)-1:0]   data_o;
    logic                               yumi_i;

    modport master (
        output v_i, a_i, b_i, c_i, yumi_i,
        input  ready_o, v_o, data_o
    );

    modport slave (
        input  v_i, a_i, b_i, c_i, yumi_i,
        output ready_o, v_o, data_o
    );

endinterface

// File: rtl/bsg_mul_add_result_fifo.sv
// Circular result FIFO with any depth; write lands next cycle, no write-to-read bypass.
// Head is registered; a read and a write in the same cycle are both honoured.
module bsg_mul_add_result_fifo
    import bsg_mul_add_pkg::*;
    #(
        parameter int width_p = 17,
        parameter int els_p   = 4
    )
    (
        input  logic               clk,
        input  logic               rst,
        input  logic               wr_vld,
        input  logic [width_p-1:0] wr_dat,
        input  logic               rd,
        output logic               rd_vld,
        output logic [width_p-1:0] rd_dat
    );

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = credit_width(els_p);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wptr;
    logic [ptr_w-1:0]   rptr;
    logic [cnt_w-1:0]   count;
    logic               full;

    // Explicit wrap so depths that are not a power of two stay in range.
    function automatic logic [ptr_w-1:0] bump(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_vld) wptr <= bump(wptr);
            if (rd)     rptr <= bump(rptr);
            if (wr_vld && !rd)      count <= count + 1'b1;
            else if (!wr_vld && rd) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) mem[wptr] <= wr_dat;
    end

    assign full   = (count == cnt_w'(els_p));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rptr];

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) rd |-> rd_vld);
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) (wr_vld && full) |-> rd);
`endif

endmodule

// File: rtl/bsg_mul_add_issue.sv
// Credit-gated issue stage computing a*b+c through a non-stalling pipeline into a result FIFO.
// Latency pipe_stages_p+1; ready_o drops only when every FIFO slot is already spoken for.
module bsg_mul_add_issue
    import bsg_mul_add_pkg::*;
    #(
        parameter int width_p       = 8,
        parameter int pipe_stages_p = 2,
        parameter int fifo_els_p    = 4
    )
    (
        input  logic               clk_i,
        input  logic               reset_i,
        bsg_mul_add_issue_if.slave bus
    );

    localparam int res_w  = result_width(width_p);
    localparam int cred_w = credit_width(fifo_els_p);

    logic [cred_w-1:0]        credits;
    logic                     ready;
    logic                     accept;
    logic [res_w-1:0]         sum;
    logic [pipe_stages_p-1:0] stage_vld;
    logic [res_w-1:0]         stage_dat [pipe_stages_p];

    assign ready       = (credits != '0) && !reset_i;
    assign bus.ready_o = ready;
    assign accept      = bus.v_i && ready;
    assign sum         = res_w'(bus.a_i) * res_w'(bus.b_i) + res_w'(bus.c_i);

    // A credit is held from acceptance until the consumer takes the result.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credits <= cred_w'(fifo_els_p);
        end else if (accept && !bus.yumi_i) begin
            credits <= credits - 1'b1;
        end else if (!accept && bus.yumi_i) begin
            credits <= credits + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stage_vld <= '0;
        end else begin
            stage_vld[0] <= accept;
            for (int i = 1; i < pipe_stages_p; i++) stage_vld[i] <= stage_vld[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        stage_dat[0] <= sum;
        for (int i = 1; i < pipe_stages_p; i++) stage_dat[i] <= stage_dat[i-1];
    end

    bsg_mul_add_result_fifo #(
        .width_p (res_w),
        .els_p   (fifo_els_p)
    ) result_fifo (
        .clk    (clk_i),
        .rst    (reset_i),
        .wr_vld (stage_vld[pipe_stages_p-1]),
        .wr_dat (stage_dat[pipe_stages_p-1]),
        .rd     (bus.yumi_i),
        .rd_vld (bus.v_o),
        .rd_dat (bus.data_o)
    );

`ifndef SYNTHESIS
    a_credit_range: assert property (@(posedge clk_i) disable iff (reset_i)
        credits <= cred_w'(fifo_els_p));
    a_credit_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(bus.yumi_i && !accept && credits == cred_w'(fifo_els_p)));
`endif

endmodule

// File: doc/bsg_mul_add_issue.md
# bsg_mul_add_issue

Credit-flow issue stage for the unsigned multiply-add datapath. Accepts operand triples (a, b, c) over valid/ready and computes a*b+c through a fixed-depth register pipeline. Results land in a small output FIFO drained by a valid/yumi consumer. Credits equal to the FIFO depth are tracked so an accepted operation always has a guaranteed result slot, and the pipeline itself never stalls.

## Interface

Parameters:
- width_p, 8, width of operands a and b
- pipe_stages_p, 2, register stages between operand acceptance and FIFO write; legal range >= 1
- fifo_els_p, 4, output FIFO depth and credit count; legal range >= 1, need not be a power of two

Ports:
- clk_i  in  1  clock, all state on rising edge
- reset_i  in  1  asynchronous, active-high reset
- v_i  in  1  operand triple valid
- a_i  in  width_p  multiplicand
- b_i  in  width_p  multiplier
- c_i  in  2*width_p  addend
- ready_o  out  1  stage can accept this cycle
- v_o  out  1  result at FIFO head valid
- data_o  out  2*width_p+1  a*b+c, unsigned, never truncated
- yumi_i  in  1  consumer takes data_o this cycle

## Operation

- Accept when v_i & ready_o. ready_o = (credits != 0). ready_o does not depend on v_i.
- Credit counter:
  - width is $clog2(fifo_els_p+1); reset value fifo_els_p.
  - Decrements on accept; increments on yumi_i; unchanged when both occur in the same cycle.
  - Invariant: credits + in-flight + FIFO count == fifo_els_p.
- Arithmetic: full-precision unsigned, a*b zero-extended to 2*width_p+1, plus c zero-extended. Computed combinationally at accept and carried through the stages.
- Pipeline:
  - pipe_stages_p data registers, each paired with a valid bit.
  - Valid bits reset to 0. Data registers are not reset.
  - Advances every cycle with no stall path.
- FIFO:
  - Written when the last stage's valid bit is 1. Read on yumi_i.
  - Circular buffer; read and write pointers wrap from fifo_els_p-1 to 0. Occupancy count resets to 0.
  - v_o = (count != 0); data_o = entry at the head.
  - Simultaneous write and read on an empty FIFO: the write lands and v_o rises next cycle, with no bypass. Simultaneous write and read on a full FIFO is legal.
- Illegal, flagged by assertions (synthesis off):
  - yumi_i while v_o == 0
  - FIFO write while full
  - credits leaving the range [0, fifo_els_p]

## Timing

- Reset values: ready_o is 0 while reset_i is asserted and 1 in the first cycle after deassertion; v_o = 0.
- Reset mid-operation: all in-flight results and FIFO contents are discarded, and credits return to fifo_els_p.
- Latency: accept in cycle k, result enters the FIFO at the end of cycle k+pipe_stages_p. With the FIFO empty, v_o is high in cycle k+pipe_stages_p+1, so latency is pipe_stages_p+1.
- Throughput: 1 op/cycle sustained when yumi_i is asserted each cycle v_o is high.
- Credit return: a yumi in cycle j raises ready_o in cycle j+1 if credits were 0.
- Cycle behaviour is purely edge-registered; no output depends combinationally on v_i.

## Structure

- Shared package bsg_mul_add_pkg:
  - result-width function (2*width_p+1)
  - credit-width function ($clog2(els+1))
- Sub-module bsg_mul_add_result_fifo: the circular FIFO with pointers, count, v_o, data_o and its assertions, parameterised by width and els.
- Top level holds the credit counter, the compute, and the valid/data stage registers.

## Test plan

- Single op, defaults: a=255, b=255, c=65535 accepted in cycle 0 → v_o in cycle 3 with data_o=0x1FE00; yumi → v_o=0.
- Credit exhaustion: v_i held high with yumi_i=0 → exactly 4 accepts, then ready_o=0. The FIFO fills with 4 results, in order. One yumi → ready_o=1 next cycle → one more accept.
- Simultaneous accept and yumi with credits=0: after the first yumi, drive v_i and yumi_i every cycle → credits stay at 0/1 as specified, no loss or duplication, 20 ops checked against a scoreboard.
- Non-power-of-two depth: fifo_els_p=3, 10 ops with random yumi → pointers wrap correctly and the output order matches the input order.
- Reset mid-flight: 2 ops in the pipe and 2 in the FIFO, then assert reset_i for 1 cycle → v_o=0 immediately. After deassertion: ready_o=1, credits=4, no stale result appears in the next 10 cycles.
- Zero operands: a=0, b=0, c=0 → data_o=0. a=1, b=0, c=0xFFFF → data_o=0x0FFFF.
